// File: rtl/prog_exc_handler.sv
// Program-interrupt sequencer: capture the fault, drain the pipe, write
// SRR0/SRR1/ESR, redirect to the program vector with a masked MSR, then ack.
module prog_exc_handler #(
   parameter int unsigned DRAIN_MAX = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        progErr,
   input  logic [2:0]  progErrCode,
   input  logic [0:31] curPC,
   input  logic [0:31] MSR,
   input  logic [0:31] IVPR,
   input  logic [0:31] IVOR6,
   input  logic        pipeEmpty,
   output logic        ack,
   output logic        flush,
   output logic        srr0_we,
   output logic        srr1_we,
   output logic        esr_we,
   output logic [0:31] srr0_wd,
   output logic [0:31] srr1_wd,
   output logic [0:31] esr_wd,
   output logic        msr_we,
   output logic [0:31] msr_wd,
   output logic        npc_we,
   output logic [0:31] npc,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, CAPTURE, DRAIN, SAVE, REDIRECT, ACK} state_t;

   // Last drain count before giving up on pipeEmpty.
   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  code_q, code_d;
   logic [0:31] pc_q, pc_d;
   logic [0:31] msr_q, msr_d;
   logic [0:15] vpfx_q, vpfx_d;   // IVPR[0:15]
   logic [0:11] voff_q, voff_d;   // IVOR6[16:27]

   // Only the vector-relevant bits of IVPR/IVOR6 are kept.
   logic unused_vec_bits;
   assign unused_vec_bits = ^{IVPR[16:31], IVOR6[0:15], IVOR6[28:31]};

   // State and latched fault context; everything clears asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         code_q  <= '0;
         pc_q    <= '0;
         msr_q   <= '0;
         vpfx_q  <= '0;
         voff_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         pc_q    <= pc_d;
         msr_q   <= msr_d;
         vpfx_q  <= vpfx_d;
         voff_q  <= voff_d;
      end
   end

   // Next state and per-state outputs; every output is zero outside its state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      pc_d    = pc_q;
      msr_d   = msr_q;
      vpfx_d  = vpfx_q;
      voff_d  = voff_q;
      ack     = 1'b0;
      flush   = 1'b0;
      srr0_we = 1'b0;
      srr1_we = 1'b0;
      esr_we  = 1'b0;
      srr0_wd = '0;
      srr1_wd = '0;
      esr_wd  = '0;
      msr_we  = 1'b0;
      msr_wd  = '0;
      npc_we  = 1'b0;
      npc     = '0;
      busy    = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (progErr) state_d = CAPTURE;
         end
         CAPTURE: begin
            flush   = 1'b1;
            code_d  = progErrCode;
            pc_d    = curPC;
            msr_d   = MSR;
            vpfx_d  = IVPR[0:15];
            voff_d  = IVOR6[16:27];
            cnt_d   = '0;
            state_d = DRAIN;
         end
         DRAIN: begin
            flush = 1'b1;
            cnt_d = cnt_q + 8'd1;
            if (pipeEmpty || cnt_q == DRAIN_LAST) state_d = SAVE;
         end
         SAVE: begin
            srr0_we = 1'b1;
            srr1_we = 1'b1;
            esr_we  = 1'b1;
            srr0_wd = pc_q;
            srr1_wd = msr_q;
            // Priority: illegal (PIL) > privilege (PPR) > trap (PTR).
            if (code_q[2])      esr_wd[4] = 1'b1;
            else if (code_q[1]) esr_wd[5] = 1'b1;
            else if (code_q[0]) esr_wd[6] = 1'b1;
            state_d = REDIRECT;
         end
         REDIRECT: begin
            npc_we     = 1'b1;
            msr_we     = 1'b1;
            npc        = {vpfx_q, voff_q, 4'b0000};
            // Keep CE, ME, DE; everything else is cleared on entry.
            msr_wd[14] = msr_q[14];
            msr_wd[19] = msr_q[19];
            msr_wd[22] = msr_q[22];
            state_d    = ACK;
         end
         ACK: begin
            ack     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_prog_exc_handler.sv
// Randomized bench for prog_exc_handler with a cycle-timeline reference model.
module tb_prog_exc_handler;

   localparam int DMAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        progErr = 1'b0;
   logic [2:0]  progErrCode = '0;
   logic [0:31] curPC = '0, MSR = '0, IVPR = '0, IVOR6 = '0;
   logic        pipeEmpty = 1'b0;
   logic        ack, flush, srr0_we, srr1_we, esr_we, msr_we, npc_we, busy;
   logic [0:31] srr0_wd, srr1_wd, esr_wd, msr_wd, npc;

   int n_tests = 0;
   int n_fail  = 0;

   prog_exc_handler #(.DRAIN_MAX(DMAX)) dut (
      .clk(clk), .rst(rst), .progErr(progErr), .progErrCode(progErrCode),
      .curPC(curPC), .MSR(MSR), .IVPR(IVPR), .IVOR6(IVOR6), .pipeEmpty(pipeEmpty),
      .ack(ack), .flush(flush), .srr0_we(srr0_we), .srr1_we(srr1_we), .esr_we(esr_we),
      .srr0_wd(srr0_wd), .srr1_wd(srr1_wd), .esr_wd(esr_wd), .msr_we(msr_we),
      .msr_wd(msr_wd), .npc_we(npc_we), .npc(npc), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ctl();
      return {flush, busy, srr0_we, srr1_we, esr_we, msr_we, npc_we, ack};
   endfunction

   function automatic logic any_out();
      return |{ctl(), srr0_wd, srr1_wd, esr_wd, msr_wd, npc};
   endfunction

   // One exception; k = index of the first DRAIN cycle that sees pipeEmpty.
   task automatic run_exc(input logic [2:0] code, input logic [0:31] pc, input logic [0:31] msr,
                          input logic [0:31] ivpr, input logic [0:31] ivor6, input int k);
      int          d;
      logic [31:0] e_esr, e_msr, e_npc;
      logic [7:0]  e_ctl;
      d = (k + 1 < DMAX) ? k + 1 : DMAX;
      if (code[2])      e_esr = 32'h1 << (31 - 4);
      else if (code[1]) e_esr = 32'h1 << (31 - 5);
      else if (code[0]) e_esr = 32'h1 << (31 - 6);
      else              e_esr = 32'h0;
      e_msr = msr & ((32'h1 << (31 - 14)) | (32'h1 << (31 - 19)) | (32'h1 << (31 - 22)));
      e_npc = (ivpr & 32'hFFFF_0000) | (ivor6 & 32'h0000_FFF0);
      @(posedge clk); #1;
      progErr = 1'b1; progErrCode = code; curPC = pc; MSR = msr; IVPR = ivpr; IVOR6 = ivor6;
      pipeEmpty = 1'b1;
      @(posedge clk);
      // Cycle j after the sampling edge: 1 = CAPTURE, 2..d+1 DRAIN, then SAVE, REDIRECT, ACK.
      for (int j = 1; j <= d + 6; j++) begin
         #1;
         if (j == d + 5) progErr = 1'b0;   // requester drops the cycle after ack
         pipeEmpty = (j == 1) ? 1'b1 : ((j - 2) >= k);
         if (j >= 2) begin
            curPC = $urandom; MSR = $urandom; IVPR = $urandom; IVOR6 = $urandom;
            progErrCode = 3'($urandom);
         end
         @(negedge clk);
         e_ctl = {j <= d + 1, j <= d + 4, {3{j == d + 2}}, j == d + 3, j == d + 3, j == d + 4};
         chk($sformatf("ctl d%0d c%0d", d, j), 32'(ctl()), 32'(e_ctl));
         if (srr0_we) begin
            chk("srr0_wd", srr0_wd, pc);
            chk("srr1_wd", srr1_wd, msr);
            chk("esr_wd", esr_wd, e_esr);
         end
         if (npc_we) begin
            chk("npc", npc, e_npc);
            chk("msr_wd", msr_wd, e_msr);
         end
         @(posedge clk);
      end
   endtask

   initial begin
      // Reset state
      #3;
      chk("reset_outs", 32'(any_out()), 32'h0);
      @(posedge clk); @(negedge clk);
      chk("reset_outs_clk", 32'(any_out()), 32'h0);
      @(posedge clk); #1 rst = 1'b1;

      // Privilege fault directed case, empty pipe
      run_exc(3'b010, 32'h0000_1000, 32'h0002_4000, 32'hFFFF_0000, 32'h0000_0700, 0);
      // All code bits: illegal wins
      run_exc(3'b111, 32'h0000_2000, 32'h0, 32'h1234_0000, 32'h0000_0700, 0);
      // Never empty: drain capped at DRAIN_MAX
      run_exc(3'b001, 32'hDEAD_BEE0, 32'h5555_AAAA, 32'hABCD_0000, 32'h0000_1230, DMAX + 2);
      // MSR all ones: only CE/ME/DE survive
      run_exc(3'b100, 32'h0000_0040, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_FFFF, 1);
      // Empty code still completes with ESR zero
      run_exc(3'b000, 32'h0000_0100, 32'h0000_1200, 32'h0001_0000, 32'hFFFF_FFFF, 2);
      // Empty seen exactly on the last allowed drain cycle
      run_exc(3'b011, 32'h0000_0300, 32'h0002_0000, 32'h0002_0000, 32'h0000_0010, DMAX - 1);

      // Reset in the middle of DRAIN
      @(posedge clk); #1;
      progErr = 1'b1; progErrCode = 3'b010; pipeEmpty = 1'b0;
      @(posedge clk);            // sampled -> CAPTURE
      @(posedge clk);            // DRAIN
      @(posedge clk); #3;        // second DRAIN cycle
      rst = 1'b0; progErr = 1'b0;
      #1;
      chk("rst_mid_async", 32'(any_out()), 32'h0);
      @(posedge clk); @(posedge clk); #1 rst = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk($sformatf("post_rst c%0d", j), 32'(ctl()), 32'h0);
      end
      run_exc(3'b100, 32'h0000_4000, 32'h0008_0200, 32'hC000_0000, 32'h0000_0300, 0);

      // Randomized exceptions
      for (int t = 0; t < 30; t++) begin
         run_exc(3'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom_range(0, DMAX + 1));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
